// File: rtl/mips_cpu_muldiv_seq.sv
`timescale 1ns/1ps
// Sequential MIPS multiply/divide unit: MULT/MULTU/DIV/DIVU in 33 edges.
// Ports: clk, reset (async low), clk_enable, start, op, op_a, op_b,
//   mthi, mtlo, mt_data in; busy, done, hi, lo out.
module mips_cpu_muldiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_enable,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] mt_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        div_q, div_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic [31:0] opnd_q, opnd_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        is_div, is_sgn;
   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;

   assign is_div = op[1];
   assign is_sgn = ~op[0];
   assign a_neg  = is_sgn & op_a[31];
   assign b_neg  = is_sgn & op_b[31];
   assign a_mag  = a_neg ? (~op_a + 32'd1) : op_a;
   assign b_mag  = b_neg ? (~op_b + 32'd1) : op_b;

   // Multiply: acc = {partial, multiplier}; add on LSB, shift right
   // with the carry out of the add.
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   assign mul_sum = {1'b0, acc_q[63:32]}
                  + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_nxt = {mul_sum, acc_q[31:1]};

   // Divide: acc = {remainder, dividend}; restoring step on the
   // 33-bit shifted remainder, quotient bit enters at the LSB.
   logic        div_ge;
   logic [31:0] rem_sub;
   logic [63:0] div_nxt;
   assign div_ge  = acc_q[63:31] >= {1'b0, opnd_q};
   assign rem_sub = acc_q[62:31] - opnd_q;
   assign div_nxt = div_ge ? {rem_sub, acc_q[30:0], 1'b1}
                           : {acc_q[62:0], 1'b0};

   logic [63:0] mul_res;
   logic [31:0] quo_res, rem_res;
   logic        div_zero;
   assign mul_res  = (sa_q ^ sb_q) ? (~acc_q + 64'd1) : acc_q;
   assign div_zero = (opnd_q == 32'd0);
   // With a zero divisor the loop leaves |op_a| in the remainder and
   // all ones in the quotient; restoring the sign gives back op_a.
   assign quo_res  = div_zero ? 32'hFFFF_FFFF :
                     (sa_q ^ sb_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign rem_res  = sa_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               div_d   = is_div;
               sa_d    = a_neg;
               sb_d    = b_neg;
               opnd_d  = is_div ? b_mag : a_mag;
               acc_d   = {32'd0, is_div ? a_mag : b_mag};
               cnt_d   = 6'd0;
               state_d = S_CALC;
            end else begin
               if (mthi) hi_d = mt_data;
               if (mtlo) lo_d = mt_data;
            end
         end
         S_CALC: begin
            acc_d = div_q ? div_nxt : mul_nxt;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) state_d = S_FIX;
         end
         S_FIX: begin
            if (div_q) begin
               hi_d = rem_res;
               lo_d = quo_res;
            end else begin
               hi_d = mul_res[63:32];
               lo_d = mul_res[31:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Gated edges hold everything, including a pending done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 6'd0;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         opnd_q  <= 32'd0;
         acc_q   <= 64'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else if (clk_enable) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == S_CALC) || (state_q == S_FIX);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: doc/mips_cpu_muldiv_seq.md
MIPS_CPU_MULDIV_SEQ -- requirements
Module: mips_cpu_muldiv_seq

Interface
REQ-001 SHALL: clk  input  1  single rising-edge clock.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL: clk_enable  input  1  state advances only on edges where high.
REQ-004 SHALL: start  input  1  request new operation.
REQ-005 SHALL: op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL: op_a  input  32  Rs (multiplicand / dividend).
REQ-007 SHALL: op_b  input  32  Rt (multiplier / divisor).
REQ-008 SHALL: mthi, mtlo  input  1 each  direct HI/LO write strobes.
REQ-009 SHALL: mt_data  input  32  data for mthi/mtlo.
REQ-010 SHALL: busy  output  1  operation in progress; CPU stalls MFHI/MFLO/new mult-div while high.
REQ-011 SHALL: done  output  1  one-cycle completion pulse.
REQ-012 SHALL: hi, lo  output  32 each  architectural HI/LO registers.

Function
REQ-013 SHALL: states IDLE, CALC, FIX; busy=1 in CALC and FIX only.
REQ-014 SHALL: IDLE with start=1 at enabled edge E0: capture op, operand signs, unsigned magnitudes (abs for signed ops, raw for unsigned), clear 6-bit counter, go CALC.
REQ-015 SHALL: CALC performs one radix-2 iteration per enabled edge: shift-add for multiply, restoring shift-subtract for divide, on 64-bit working register.
REQ-016 SHALL: after 32 iterations (edges E1..E32) go FIX at E32.
REQ-017 SHALL: at E33 (FIX) write hi/lo with sign correction, pulse done high for the cycle after E33, return IDLE; fixed latency 33 enabled edges for all ops and operands.
REQ-018 SHALL: multiply result {hi,lo} = full 64-bit product; MULT negates 64-bit magnitude when operand signs differ.
REQ-019 SHALL: divide lo=quotient, hi=remainder; DIV quotient negated when signs differ, remainder takes dividend sign.
REQ-020 SHALL: DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0x00000000.
REQ-021 SHALL: divide by zero (either op) yields hi=op_a as captured, lo=0xFFFFFFFF, same latency.
REQ-022 SHALL: start while busy ignored; no queuing.
REQ-023 SHALL: start in the done cycle (IDLE) accepted; back-to-back operations, no bubble.
REQ-024 SHALL: mthi/mtlo in IDLE without start write mt_data to hi/lo at that edge; both may write in same edge.
REQ-025 SHALL: mthi/mtlo ignored while busy or when start accepted in same edge (start wins).
REQ-026 SHALL: clk_enable low freezes state, counter, working registers, hi, lo; done held low unless already high, then held for the extended cycle.
REQ-027 SHALL: hi/lo hold previous values throughout CALC; updated only in FIX or by mthi/mtlo.

Reset
REQ-028 SHALL: reset low asynchronously forces IDLE, counter=0, hi=0, lo=0, busy=0, done=0, working registers=0, independent of clk and clk_enable.
REQ-029 SHALL: reset mid-operation abandons operation; no done pulse follows reset release.
REQ-030 SHALL: first start accepted on first enabled edge after reset high.

Verification
REQ-031 SHALL: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> 33 edges later hi=0xFFFFFFFE, lo=0x00000001, done high exactly one cycle, busy high 33 cycles.
REQ-032 SHALL: MULT 0xFFFFFFFD x 0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-033 SHALL: DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL: DIVU 0x00000005 / 0 -> hi=0x00000005, lo=0xFFFFFFFF.
REQ-035 SHALL: start and mthi=1 (mt_data=0x1234) during CALC, clk_enable low 5 cycles -> no restart, hi unchanged by mthi, done after 38 clocks.
REQ-036 SHALL: reset low at iteration 10 with clk stopped -> busy=0, hi=lo=0 immediately; no done after release.
